// File: rtl/liteic_master_node_read.sv
// liteic_master_node_read
// Read-side node for one AXI-Lite master. Accepts a single AR, decodes it to
// a crossbar slave slot, issues the slot request and returns that slot's R
// beat to the master. Addresses that hit no slot are answered locally with
// DECERR. Only one read is in flight at a time.
module liteic_master_node_read #(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE_ADDR =
      {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_ADDR_MASK =
      {4{32'hF000_0000}}
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    mst_ar_valid_i,
   output logic                    mst_ar_ready_o,
   input  logic [ADDR_WIDTH-1:0]   mst_ar_addr_i,
   input  logic [3:0]              mst_ar_qos_i,
   output logic                    mst_r_valid_o,
   input  logic                    mst_r_ready_i,
   output logic [DATA_WIDTH-1:0]   mst_r_data_o,
   output logic [1:0]              mst_r_resp_o,
   output logic [ADDR_WIDTH-1:0]   cbar_reqst_data_o,
   output logic [3:0]              cbar_reqst_arqos_o,
   output logic [NUM_SLAVES-1:0]   cbar_reqst_val_o,
   input  logic [NUM_SLAVES-1:0]   cbar_reqst_rdy_i,
   input  logic [NUM_SLAVES-1:0]   cbar_resp_val_i,
   output logic [NUM_SLAVES-1:0]   cbar_resp_rdy_o,
   input  logic [DATA_WIDTH+1:0]   cbar_resp_data_i [NUM_SLAVES]
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [NUM_SLAVES-1:0]  sel_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [3:0]             qos_q;
   logic [NUM_SLAVES-1:0]  hit_oh;
   logic                   hit_any;
   logic [IDX_W-1:0]       sel_idx;
   logic                   slot_rvalid;
   logic                   ar_hs;

   assign ar_hs = (state_q == S_IDLE) && mst_ar_valid_i;

   // Address decode: lowest-index matching slot wins, so overlapping windows are allowed.
   always_comb begin
      hit_oh  = '0;
      hit_any = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!hit_any &&
             ((mst_ar_addr_i & SLV_ADDR_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
              (SLV_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] & SLV_ADDR_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
            hit_oh[i] = 1'b1;
            hit_any   = 1'b1;
         end
      end
   end

   // Convert the latched one-hot slot select into an index for the R data mux.
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) sel_idx = IDX_W'(i);
      end
   end

   assign slot_rvalid = |(sel_q & cbar_resp_val_i);

   // State register; reset drops any in-flight transfer.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Request capture: address, QoS and slot select are frozen for the whole transaction.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sel_q  <= '0;
         addr_q <= '0;
         qos_q  <= '0;
      end else if (ar_hs) begin
         sel_q  <= hit_oh;
         addr_q <= mst_ar_addr_i;
         qos_q  <= mst_ar_qos_i;
      end
   end

   // Next-state logic: only the selected slot's handshakes can advance the FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (mst_ar_valid_i) state_d = hit_any ? S_REQ : S_ERR;
         S_REQ:  if (|(sel_q & cbar_reqst_rdy_i)) state_d = S_RESP;
         S_RESP: if (slot_rvalid && mst_r_ready_i) state_d = S_IDLE;
         S_ERR:  if (mst_r_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: request in REQ, pass-through R path in RESP, local DECERR in ERR.
   always_comb begin
      mst_ar_ready_o   = 1'b0;
      mst_r_valid_o    = 1'b0;
      mst_r_data_o     = '0;
      mst_r_resp_o     = 2'b00;
      cbar_reqst_val_o = '0;
      cbar_resp_rdy_o  = '0;
      case (state_q)
         S_IDLE: mst_ar_ready_o = 1'b1;
         S_REQ:  cbar_reqst_val_o = sel_q;
         S_RESP: begin
            mst_r_valid_o   = slot_rvalid;
            mst_r_data_o    = cbar_resp_data_i[sel_idx][DATA_WIDTH+1:2];
            mst_r_resp_o    = cbar_resp_data_i[sel_idx][1:0];
            cbar_resp_rdy_o = sel_q & {NUM_SLAVES{mst_r_ready_i}};
         end
         S_ERR: begin
            mst_r_valid_o = 1'b1;
            mst_r_resp_o  = 2'b11;
         end
         default: ;
      endcase
   end

   assign cbar_reqst_data_o  = addr_q;
   assign cbar_reqst_arqos_o = qos_q;

endmodule
